uart_frame_checker: RTL and testbench

Parametrised, registered receive-frame checker for the UART Rx path. It sits between the Rx SIPO and the receive FIFO or host interface, and takes one complete captured frame per `frame_valid` pulse. It checks start, parity and stop bits, and detects line break. It presents the data word and per-frame error flags through a single-entry valid/ready output register, and keeps sticky status, an overrun indication and an optional saturating error counter.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sat_counter.sv | 22 ++
 rtl/uart_frame_checker.sv | 116 +++++++++++
 tb/tb_uart_frame_checker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, error-flag bit positions and the parity check.
package uart_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  localparam int unsigned ERR_PARITY = 0;
  localparam int unsigned ERR_START  = 1;
  localparam int unsigned ERR_STOP   = 2;
  localparam int unsigned ERR_BREAK  = 3;

  localparam int unsigned MAX_DATA_W = 9;

  // Data is zero-extended to the widest legal word; padding zeros leave the XOR unchanged.
  function automatic logic calc_parity_err(input logic [MAX_DATA_W-1:0] data,
                                           input logic                  slot,
                                           input logic [1:0]            par_type);
    logic p;
    p = (^data) ^ slot;
    case (par_type)
      PAR_ODD:  calc_parity_err = ~p;
      PAR_EVEN: calc_parity_err = p;
      default:  calc_parity_err = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with an increment loads 1.
module uart_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_frame_checker.sv
// UART Rx frame checker: start/parity/stop/break checks into a one-entry valid/ready register.
// Optional saturating error counter on err_count when UART_FRAME_ERR_COUNT_EN is defined.
module uart_frame_checker
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int STOP_BITS  = 1,
  parameter  int CNT_WIDTH  = 8,
  localparam int FRAME_W    = DATA_WIDTH + 2 + STOP_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            parity_type,
  input  logic                  frame_valid,
  input  logic [FRAME_W-1:0]    frame_bits,
  output logic                  frame_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [3:0]            err_flags,
  output logic [3:0]            sticky_err,
  output logic                  overrun,
  input  logic                  clear_status
`ifdef UART_FRAME_ERR_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  err_count
`endif
);

  if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (CNT_WIDTH < 2)) begin : g_bad_param
    $error("uart_frame_checker: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] rx_data;
  logic [STOP_BITS-1:0]  rx_stop;
  logic [MAX_DATA_W-1:0] rx_data_pad;
  logic                  is_break;
  logic [3:0]            flags_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  accept;
  logic                  drop;

  assign rx_data  = frame_bits[DATA_WIDTH:1];
  assign rx_stop  = frame_bits[FRAME_W-1:DATA_WIDTH+2];
  assign is_break = (frame_bits == '0);

  assign frame_ready = ~data_valid | data_ready;
  assign accept      = frame_valid & frame_ready;
  assign drop        = frame_valid & ~frame_ready;

  always_comb begin
    rx_data_pad                 = '0;
    rx_data_pad[DATA_WIDTH-1:0] = rx_data;
    flags_next                  = '0;
    data_next                   = rx_data;
    if (is_break) begin
      flags_next[ERR_BREAK] = 1'b1;
      data_next             = '0;
    end else begin
      flags_next[ERR_PARITY] = calc_parity_err(rx_data_pad, frame_bits[DATA_WIDTH+1], parity_type);
      flags_next[ERR_START]  = frame_bits[0];
      flags_next[ERR_STOP]   = ~&rx_stop;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      err_flags  <= '0;
    end else if (accept) begin
      data_valid <= 1'b1;
      data_out   <= data_next;
      err_flags  <= flags_next;
    end else if (data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // A clear in the same cycle as an event keeps that event's status.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_err <= '0;
      overrun    <= 1'b0;
    end else begin
      if (clear_status) begin
        sticky_err <= accept ? flags_next : '0;
      end else if (accept) begin
        sticky_err <= sticky_err | flags_next;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_FRAME_ERR_COUNT_EN
  logic cnt_inc;

  assign cnt_inc = (accept & (|flags_next)) | drop;

  uart_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (cnt_inc),
    .clr  (clear_status),
    .count(err_count)
  );
`endif

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed self-checking bench for uart_frame_checker (DATA_WIDTH=8, STOP_BITS=1, CNT_WIDTH=4).
module tb_uart_frame_checker;

  logic        clock;
  logic        reset;
  logic [1:0]  parity_type;
  logic        frame_valid;
  logic [10:0] frame_bits;
  logic        frame_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  err_flags;
  logic [3:0]  sticky_err;
  logic        overrun;
  logic        clear_status;
`ifdef UART_FRAME_ERR_COUNT_EN
  logic [3:0]  err_count;
`endif

  int total;
  int bad;

  uart_frame_checker #(
    .DATA_WIDTH(8),
    .STOP_BITS (1),
    .CNT_WIDTH (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .parity_type (parity_type),
    .frame_valid (frame_valid),
    .frame_bits  (frame_bits),
    .frame_ready (frame_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .err_flags   (err_flags),
    .sticky_err  (sticky_err),
    .overrun     (overrun),
    .clear_status(clear_status)
`ifdef UART_FRAME_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    parity_type  = 2'b10;
    frame_valid  = 1'b0;
    frame_bits   = '0;
    data_ready   = 1'b0;
    clear_status = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if (err_flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", err_flags); end
    total++; if (sticky_err !== 4'b0000) begin bad++; $display("FAIL reset_sticky got=%b exp=0000", sticky_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL reset_frame_ready got=%b exp=1", frame_ready); end
`ifdef UART_FRAME_ERR_COUNT_EN
    total++; if (err_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", err_count); end
`endif
  endtask

  task automatic test_clean_frame();
    parity_type = 2'b10;
    data_ready  = 1'b0;
    frame_bits  = 11'h4AA;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL clean_valid got=%b exp=1", data_valid); end
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL clean_data got=%h exp=55", data_out); end
    total++; if (err_flags !== 4'b0000) begin bad++; $display("FAIL clean_flags got=%b exp=0000", err_flags); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL clean_full_ready got=%b exp=0", frame_ready); end
    tick();
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL clean_hold got=%h exp=55", data_out); end
    data_ready = 1'b1;
    tick();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL clean_drain got=%b exp=0", data_valid); end
  endtask

  task automatic test_parity();
    parity_type = 2'b01;
    frame_bits  = 11'h4AA;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    parity_type = 2'b10;
    total++; if (err_flags !== 4'b0001) begin bad++; $display("FAIL parity_flags got=%b exp=0001", err_flags); end
    total++; if (sticky_err !== 4'b0001) begin bad++; $display("FAIL parity_sticky got=%b exp=0001", sticky_err); end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    total++; if (sticky_err !== 4'b0000) begin bad++; $display("FAIL parity_clear got=%b exp=0000", sticky_err); end
    // none encoding 11 ignores a wrong parity slot
    parity_type = 2'b11;
    frame_bits  = 11'h6AA;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    total++; if (err_flags !== 4'b0000) begin bad++; $display("FAIL parity_none_flags got=%b exp=0000", err_flags); end
    parity_type = 2'b10;
    tick();
  endtask

  task automatic test_stop_break();
    data_ready  = 1'b1;
    frame_bits  = 11'h0AA;
    frame_valid = 1'b1;
    tick();
    total++; if (err_flags !== 4'b0100) begin bad++; $display("FAIL stop_flags got=%b exp=0100", err_flags); end
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL stop_data got=%h exp=55", data_out); end
    frame_bits = 11'h000;
    tick();
    frame_valid = 1'b0;
    total++; if (err_flags !== 4'b1000) begin bad++; $display("FAIL break_flags got=%b exp=1000", err_flags); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL break_data got=%h exp=00", data_out); end
    total++; if (sticky_err !== 4'b1100) begin bad++; $display("FAIL break_sticky got=%b exp=1100", sticky_err); end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  task automatic test_overrun();
    data_ready  = 1'b0;
    frame_bits  = 11'h4AA;
    frame_valid = 1'b1;
    tick();
    frame_bits = 11'h402;
    tick();
    frame_valid = 1'b0;
    total++; if (data_out !== 8'h55) begin bad++; $display("FAIL ovr_data got=%h exp=55", data_out); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", data_valid); end
    data_ready = 1'b1;
    tick();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b exp=0", data_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    data_ready  = 1'b0;
    frame_bits  = 11'h4AA;
    frame_valid = 1'b1;
    tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    frame_valid  = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_clear_drop got=%b exp=1", overrun); end
    data_ready   = 1'b1;
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [4];
    vec[0] = 8'h01; vec[1] = 8'hFF; vec[2] = 8'h80; vec[3] = 8'h3C;
    data_ready  = 1'b1;
    parity_type = 2'b10;
    for (int i = 0; i < 4; i++) begin
      frame_bits  = {1'b1, ^vec[i], vec[i], 1'b0};
      frame_valid = 1'b1;
      total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, frame_ready); end
      tick();
      total++; if (data_out !== vec[i] || err_flags !== 4'b0000 || data_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_out[%0d] got=%h/%b/%b exp=%h/0000/1", i, data_out, err_flags, data_valid, vec[i]);
      end
    end
    frame_valid = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    tick();
  endtask

  task automatic test_mid_reset();
    data_ready  = 1'b0;
    frame_bits  = 11'h0AA;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    total++; if (sticky_err !== 4'b0100) begin bad++; $display("FAIL mid_pre_sticky got=%b exp=0100", sticky_err); end
    reset       = 1'b1;
    frame_bits  = 11'h4AA;
    frame_valid = 1'b1;
    tick();
    reset       = 1'b0;
    frame_valid = 1'b0;
    total++; if ({data_valid, data_out, err_flags, sticky_err, overrun} !== 18'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%b/%b/%b exp=all zero", data_valid, data_out, err_flags, sticky_err, overrun);
    end
    data_ready = 1'b1;
  endtask

`ifdef UART_FRAME_ERR_COUNT_EN
  task automatic test_counter();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    data_ready   = 1'b1;
    frame_bits   = 11'h4AB;
    frame_valid  = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    frame_valid = 1'b0;
    total++; if (err_count !== 4'd15) begin bad++; $display("FAIL cnt_sat got=%0d exp=15", err_count); end
    frame_valid  = 1'b1;
    clear_status = 1'b1;
    tick();
    frame_valid  = 1'b0;
    clear_status = 1'b0;
    total++; if (err_count !== 4'd1) begin bad++; $display("FAIL cnt_clear_inc got=%0d exp=1", err_count); end
    frame_bits  = 11'h4AA;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    total++; if (err_count !== 4'd1) begin bad++; $display("FAIL cnt_clean got=%0d exp=1", err_count); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_frame();
    test_parity();
    test_stop_break();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_FRAME_ERR_COUNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
